// File: rtl/nes_pad_scanner.sv
// nes_pad_scanner: shared latch/pulse serial scanner for up to four NES pads.
// Define NES_PAD_EDGE_EN to add the press_edge one-frame strobe output.
module nes_pad_scanner #(
  parameter int NUM_PADS     = 2,
  parameter int LATCH_CYCLES = 302,
  parameter int HALF_CYCLES  = 76,
  parameter int AUTO_POLL    = 1,
  parameter int POLL_PERIOD  = 419583
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  poll_req,
  input  logic [NUM_PADS-1:0]   pad_data,
  output logic                  pad_latch,
  output logic                  pad_pulse,
  output logic [8*NUM_PADS-1:0] buttons,
  output logic                  frame_valid,
  output logic                  busy
`ifdef NES_PAD_EDGE_EN
  ,
  output logic [8*NUM_PADS-1:0] press_edge
`endif
);

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ?
                        LATCH_CYCLES : HALF_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int BW = 8 * NUM_PADS;

  localparam logic [CW-1:0] LAT_LAST  = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic [BW-1:0]       shift_q, shift_d;
  logic [BW-1:0]       buttons_q, buttons_d;
  logic [BW-1:0]       edge_q, edge_d;
  logic                latch_q, latch_d;
  logic                pulse_q, pulse_d;
  logic                fv_q, fv_d;
  logic                busy_q, busy_d;
  logic                start;
  logic                sample;

  always_comb begin
    timer_d = '0;
    if (AUTO_POLL != 0 && timer_q != POLL_LAST)
      timer_d = timer_q + 1'b1;

    // A start outside IDLE is simply dropped.
    start = (AUTO_POLL != 0) ? (timer_q == '0) : poll_req;

    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sample  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == LAT_LAST) begin
          sample  = 1'b1;
          state_d = PULSE_HI;
          cnt_d   = '0;
          bit_d   = 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE_HI: begin
        if (cnt_q == HALF_LAST) begin
          state_d = PULSE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE_LO: begin
        if (cnt_q == HALF_LAST) begin
          sample = 1'b1;
          cnt_d  = '0;
          if (bit_q == 3'd7) begin
            state_d = DONE;
            bit_d   = '0;
          end else begin
            state_d = PULSE_HI;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bits arrive LSB first; eight right shifts leave bit 0 at the bottom.
    shift_d = shift_q;
    if (sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shift_d[8*p +: 8] = {~sync2_q[p], shift_q[8*p+1 +: 7]};
      end
    end

    buttons_d = buttons_q;
    edge_d    = '0;
    if (state_d == DONE) begin
      buttons_d = shift_d;
      edge_d    = shift_d & ~buttons_q;
    end

    latch_d = (state_d == LATCH);
    pulse_d = (state_d == PULSE_HI);
    fv_d    = (state_d == DONE);
    busy_d  = (state_d == LATCH) ||
              (state_d == PULSE_HI) ||
              (state_d == PULSE_LO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      timer_q   <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      shift_q   <= '0;
      buttons_q <= '0;
      edge_q    <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      timer_q   <= timer_d;
      sync1_q   <= pad_data;
      sync2_q   <= sync1_q;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      edge_q    <= edge_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      fv_q      <= fv_d;
      busy_q    <= busy_d;
    end
  end

  assign pad_latch   = latch_q;
  assign pad_pulse   = pulse_q;
  assign buttons     = buttons_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

`ifdef NES_PAD_EDGE_EN
  assign press_edge = edge_q;
`else
  logic unused_edge;
  assign unused_edge = ^edge_q;
`endif

endmodule

// File: doc/nes_pad_scanner.md
Name: nes_pad_scanner

Overview:
- Parametrised multi-controller NES pad scanner. It generalises the fixed two-pad controller interface behind the Pong top level.
- Drives one shared latch line and one shared pulse (clock) line to NUM_PADS controllers.
- Shifts 8 buttons per pad serially from each active-low data line.
- Presents a debounced, atomically updated, active-high button vector to the game logic once per frame.
- Polls either on an internal frame timer (AUTO_POLL=1) or on request (AUTO_POLL=0).

Parameters:
- NUM_PADS, 2, number of controllers sharing latch/pulse; each has its own data input; range 1..4
- LATCH_CYCLES, 302, latch high time in clk cycles (12 us at 25.175 MHz); must be >= 3
- HALF_CYCLES, 76, pulse high time and pulse low time, each in clk cycles; must be >= 3
- AUTO_POLL, 1, 1 = scan starts every POLL_PERIOD cycles; 0 = scan starts on poll_req
- POLL_PERIOD, 419583, cycles between latch rising edges when AUTO_POLL=1 (60 Hz); must be >= LATCH_CYCLES + 14*HALF_CYCLES + 2

Ports:
- clk  in  1  system clock, 25.175 MHz
- reset  in  1  asynchronous active-high reset
- poll_req  in  1  one-cycle scan request; used only when AUTO_POLL=0, ignored while busy
- pad_data  in  NUM_PADS  serial data from each pad, active-low (0 = pressed), asynchronous
- pad_latch  out  1  shared latch to pads
- pad_pulse  out  1  shared shift clock to pads
- buttons  out  8*NUM_PADS  pad p occupies bits [8p+7:8p]; bit 0..7 = A, B, Select, Start, Up, Down, Left, Right; 1 = pressed
- frame_valid  out  1  one-cycle strobe, high in the cycle buttons updates
- busy  out  1  high from the first latch cycle through the last sample cycle

Behaviour:
- Reset (async assert, sync release): state IDLE; pad_latch, pad_pulse, busy, frame_valid = 0; buttons = 0; shift registers, counters and poll timer = 0; synchroniser flops = 1 (released).
- Each pad_data bit passes through a 2-flop synchroniser. All sampling uses the synchronised value, inverted so that pressed = 1.
- Start condition: AUTO_POLL=1 → poll timer counts 0..POLL_PERIOD-1 and fires a start at count 0, including the first cycle after reset; AUTO_POLL=0 → poll_req high while IDLE.
- States:
  - IDLE: outputs low. On start, next cycle → LATCH.
  - LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles. Bit 0 of every pad is sampled in the last LATCH cycle. → PULSE_HI with bit index k=1.
  - PULSE_HI: pad_pulse=1 for HALF_CYCLES cycles. → PULSE_LO.
  - PULSE_LO: pad_pulse=0 for HALF_CYCLES cycles. Bit k of every pad is sampled in the last cycle. If k=7 → DONE, else k+1 → PULSE_HI.
  - DONE: one cycle. Shift registers copy to buttons; frame_valid=1. → IDLE.
- Exactly 7 pulses per frame. Frame length is LATCH_CYCLES + 14*HALF_CYCLES + 1 cycles from latch rise to frame_valid.
- buttons changes only in the DONE cycle. No partial frame is ever visible.
- poll_req while busy or in DONE: ignored, not queued.
- With AUTO_POLL=1 the timer free-runs independently of state. The parameter constraint guarantees it never fires outside IDLE; if it does, the start is dropped.
- Reset mid-frame: immediate return to reset values; buttons cleared; no frame_valid.
- Disconnected pad: data floats high → reads all-zero (no buttons pressed).
- Counter widths: $clog2 of the largest count they hold. No wrap is permitted except the poll timer (POLL_PERIOD-1 → 0).

Optional Feature:
- Macro NES_PAD_EDGE_EN.
- Defined: adds output press_edge (8*NUM_PADS). In the DONE cycle it is set to new_buttons & ~buttons, using the old buttons value. Otherwise it is 0, so it is a one-cycle strobe aligned with frame_valid. Reset value 0. After reset, the first frame reports every held button as an edge.
- Not defined: port and logic absent; other behaviour identical.

Test Plan:
All tests use LATCH_CYCLES=4, HALF_CYCLES=3, POLL_PERIOD=60, NUM_PADS=2 unless stated.
- Reset hold, then release with AUTO_POLL=1 → pad_latch high on cycle 1 after release for 4 cycles; 7 pad_pulse highs of 3 cycles each; frame_valid 47 cycles after latch rise; next latch rise 60 cycles after the first.
- Pad model shifting pad0=A+Right pressed, pad1=Start pressed, data changing on pulse rising edge → buttons=16'h0881, frame_valid one cycle.
- AUTO_POLL=0, poll_req pulsed mid-frame and twice back-to-back → exactly one frame per accepted request; no extra latch.
- Assert reset during the 4th pulse with prior buttons=16'h00FF → buttons=0, latch/pulse low immediately, no frame_valid, busy=0.
- pad_data held high (unplugged) on pad1, pad0 all pressed → buttons=16'h00FF.
- NES_PAD_EDGE_EN: frames with pad0 = 8'h01, 8'h03, 8'h02 → press_edge = 16'h0001, 16'h0002, 16'h0000, each coincident with frame_valid.
